uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Serial UART transmitter that sits directly downstream of the TX top-level control stage. It consumes the control stage's byte (TX_Data) and level enable (TX_En_Sig), and serialises the byte LSB-first onto the line as start, data, optional parity and stop bits. It returns a one-cycle TX_Done_Sig that releases the control stage to fetch the next FIFO byte.

Parameters:
BIT_CYCLES, 5208, CLK cycles per bit (50 MHz / 9600 baud); legal range 2..65535.
PARITY_EN, 0, 1 = insert parity bit after data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  asynchronous, active-high reset.
TX_Data  input  8  byte to send; sampled only on frame acceptance.
TX_En_Sig  input  1  level request from the control stage; held high until TX_Done_Sig is seen.
TX_Done_Sig  output  1  one-cycle pulse when the frame's last stop bit completes.
TX_Pin_Out  output  1  serial line, idle high; registered output.
Busy_Sig  output  1  high from frame acceptance until return to IDLE.

Behaviour:
- Clocking and reset: one clock, CLK; reset is asynchronous, active-high on RST.
- Reset values: TX_Pin_Out=1, TX_Done_Sig=0, Busy_Sig=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame: line returns high immediately (asynchronous) and no Done pulse is emitted. After RST deasserts, a still-high TX_En_Sig starts a fresh frame.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> WAIT_REL -> IDLE.
- IDLE: TX_Pin_Out=1. If TX_En_Sig=1, latch TX_Data into the shift register and compute the parity bit.
  - Parity bit = XOR of data bits, inverted if PARITY_ODD=1.
  - Go to START and set Busy_Sig=1 on the next edge.
- Bit timing: every bit (start, data, parity, stop) is driven for exactly BIT_CYCLES clocks.
  - Baud counter runs 0..BIT_CYCLES-1 and clears on each bit boundary.
  - Width is ceil(log2(BIT_CYCLES)), minimum 1 bit.
- START: TX_Pin_Out=0 for one bit period.
- DATA: 8 bits LSB first, with a 3-bit index 0..7. After bit 7, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: drive the latched parity bit for one bit period.
- STOP: TX_Pin_Out=1 for STOP_BITS bit periods.
- Done pulse: on the final clock of the last stop bit, register TX_Done_Sig=1 so it is high for exactly the following one cycle. The FSM enters WAIT_REL in that same cycle.
- Latency: first start-bit clock is the cycle after acceptance. Frame length = BIT_CYCLES*(1+8+PARITY_EN+STOP_BITS) clocks. Done is asserted in the cycle after the frame's last clock.
- WAIT_REL: line high, Busy_Sig=1. Return to IDLE only once TX_En_Sig=0 is sampled, so a still-high enable in the Done cycle cannot retrigger. The control stage drops enable the cycle after Done, so the minimum gap is 1 idle cycle.
- TX_Data changes after acceptance have no effect on the frame in flight. TX_En_Sig deasserting mid-frame has no effect; the frame completes and Done still pulses.
- TX_Done_Sig is never high outside the one cycle after a completed frame.

Test Plan:
- Reset state: assert RST asynchronously mid-cycle -> TX_Pin_Out=1, TX_Done_Sig=0, Busy_Sig=0 immediately. Hold TX_En_Sig=0 for 100 cycles after release -> line stays 1.
- Basic frame: BIT_CYCLES=4, 8N1, TX_Data=0x55, TX_En_Sig raised at cycle T.
  - Line = 0 during T+1..T+4, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high.
  - TX_Done_Sig=1 only at cycle T+41; Busy_Sig high T+1 through WAIT_REL.
- Parity: BIT_CYCLES=4, PARITY_EN=1, TX_Data=0x07.
  - PARITY_ODD=0 -> parity bit = 1; PARITY_ODD=1 -> parity bit = 0.
  - Frame = 44 clocks; Done at T+45.
- Two stop bits with back-to-back handshake: STOP_BITS=2, bytes 0xA3 then 0x0F, enable dropped the cycle after Done and re-raised 2 cycles later.
  - Each frame = 44 clocks; no retrigger during WAIT_REL; second frame serialises 0x0F correctly.
- Held enable: TX_En_Sig kept high for 200 cycles after Done -> exactly one frame and one Done pulse. Lowering enable then returns the FSM to IDLE.
- Reset mid-operation: assert RST during data bit 3 of 0xFF -> line high at once, no Done pulse. Release with TX_En_Sig=1 and TX_Data=0x81 -> a complete fresh 0x81 frame starts the cycle after the first enable sample.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART serialiser fed by the TX control stage.
// Sends start bit, 8 data bits LSB first, an optional parity bit and 1 or 2 stop bits.
// Every bit is held for BIT_CYCLES clocks.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-high reset
//   TX_Data      byte to send, sampled only when a frame is accepted in IDLE
//   TX_En_Sig    level request, held high by the control stage until it sees TX_Done_Sig
//   TX_Done_Sig  one-cycle pulse in the cycle after the last stop bit ends
//   TX_Pin_Out   registered serial line, idle high
//   Busy_Sig     high from frame acceptance until the FSM is back in IDLE
module uart_tx_engine #(
    parameter int unsigned BIT_CYCLES = 5208,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] TX_Data,
    input  logic       TX_En_Sig,
    output logic       TX_Done_Sig,
    output logic       TX_Pin_Out,
    output logic       Busy_Sig
);

    localparam int unsigned     CntW     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(BIT_CYCLES - 1);
    localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);
    localparam logic            ParEn    = (PARITY_EN != 0);
    localparam logic            ParOdd   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitRel
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              pin_q, pin_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              bit_end;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        bit_end   = (baud_q == BaudLast);

        // Baud counter only runs while a bit is on the line.
        if (state_q inside {StStart, StData, StParity, StStop}) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (TX_En_Sig) begin
                    shift_d   = TX_Data;
                    parity_d  = (^TX_Data) ^ ParOdd;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = ParEn ? StParity : StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_idx_q == StopLast) begin
                        bit_idx_d = 3'd0;
                        done_d    = 1'b1;
                        state_d   = StWaitRel;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StWaitRel: begin
                // Wait for the control stage to drop its request so a held enable
                // cannot start a second frame.
                if (!TX_En_Sig) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Line is registered: derive it from the state being entered.
        unique case (state_d)
            StStart:  pin_d = 1'b0;
            StData:   pin_d = shift_d[0];
            StParity: pin_d = parity_d;
            default:  pin_d = 1'b1;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            pin_q     <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            pin_q     <= pin_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_Pin_Out  = pin_q;
    assign TX_Done_Sig = done_q;
    assign Busy_Sig    = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed bench for uart_tx_engine.
// Four instances, all BIT_CYCLES=4: 8N1, 8E1, 8O1 and 8N2.
module tb_uart_tx_engine;

    logic       clk;
    logic       rst;
    logic       en   [4];
    logic [7:0] data [4];
    logic       pin  [4];
    logic       done [4];
    logic       busy [4];

    int checks;
    int errors;

    uart_tx_engine #(.BIT_CYCLES(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .CLK(clk), .RST(rst), .TX_Data(data[0]), .TX_En_Sig(en[0]),
        .TX_Done_Sig(done[0]), .TX_Pin_Out(pin[0]), .Busy_Sig(busy[0])
    );
    uart_tx_engine #(.BIT_CYCLES(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .CLK(clk), .RST(rst), .TX_Data(data[1]), .TX_En_Sig(en[1]),
        .TX_Done_Sig(done[1]), .TX_Pin_Out(pin[1]), .Busy_Sig(busy[1])
    );
    uart_tx_engine #(.BIT_CYCLES(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .CLK(clk), .RST(rst), .TX_Data(data[2]), .TX_En_Sig(en[2]),
        .TX_Done_Sig(done[2]), .TX_Pin_Out(pin[2]), .Busy_Sig(busy[2])
    );
    uart_tx_engine #(.BIT_CYCLES(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .CLK(clk), .RST(rst), .TX_Data(data[3]), .TX_En_Sig(en[3]),
        .TX_Done_Sig(done[3]), .TX_Pin_Out(pin[3]), .Busy_Sig(busy[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line in frame cycle k (1-based) with 4 clocks per bit.
    function automatic logic exp_line(input logic [7:0] d, input int pen, input logic pb,
                                      input int k);
        int b;
        b = (k - 1) / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pen != 0 && b == 9) return pb;
        return 1'b1;
    endfunction

    task automatic test_reset();
        logic [2:0] obs;
        // Reset is asserted from time 0: outputs must be idle before any clock edge.
        #1;
        obs = {pin[0], done[0], busy[0]};
        checks++;
        if (obs !== 3'b100) begin
            errors++; $display("FAIL reset_async_init got %b want 100", obs);
        end
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            obs = {pin[0], done[0], busy[0]};
            checks++;
            if (obs !== 3'b100) begin
                errors++; $display("FAIL reset_idle cyc=%0d got %b want 100", i, obs);
            end
        end
        // Start a frame, then hit reset mid-cycle inside the start bit.
        @(posedge clk); #1 data[0] = 8'h00; en[0] = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        obs = {pin[0], done[0], busy[0]};
        checks++;
        if (obs !== 3'b001) begin
            errors++; $display("FAIL reset_pre_start got %b want 001", obs);
        end
        #2 rst = 1'b1; en[0] = 1'b0;
        #1 obs = {pin[0], done[0], busy[0]};
        checks++;
        if (obs !== 3'b100) begin
            errors++; $display("FAIL reset_async_mid got %b want 100", obs);
        end
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [2:0] obs, exp;
        @(posedge clk); #1 data[0] = 8'h55; en[0] = 1'b1;
        @(negedge clk);
        obs = {pin[0], done[0], busy[0]};
        checks++;
        if (obs !== 3'b100) begin
            errors++; $display("FAIL basic_pre got %b want 100", obs);
        end
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            obs = {pin[0], done[0], busy[0]};
            exp = {(k <= 40) ? exp_line(8'h55, 0, 1'b0, k) : 1'b1, k == 41, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL basic_frame k=%0d got %b want %b", k, obs, exp);
            end
        end
        @(posedge clk); #1 en[0] = 1'b0;
        @(negedge clk);
        obs = {pin[0], done[0], busy[0]};
        checks++;
        if (obs !== 3'b101) begin
            errors++; $display("FAIL basic_waitrel got %b want 101", obs);
        end
        @(negedge clk);
        obs = {pin[0], done[0], busy[0]};
        checks++;
        if (obs !== 3'b100) begin
            errors++; $display("FAIL basic_idle got %b want 100", obs);
        end
    endtask

    task automatic test_parity();
        logic [2:0] obs1, obs2, exp1, exp2;
        @(posedge clk); #1 data[1] = 8'h07; data[2] = 8'h07; en[1] = 1'b1; en[2] = 1'b1;
        @(negedge clk);
        // 0x07 has three ones: even parity bit 1, odd parity bit 0.
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            obs1 = {pin[1], done[1], busy[1]};
            obs2 = {pin[2], done[2], busy[2]};
            exp1 = {(k <= 44) ? exp_line(8'h07, 1, 1'b1, k) : 1'b1, k == 45, 1'b1};
            exp2 = {(k <= 44) ? exp_line(8'h07, 1, 1'b0, k) : 1'b1, k == 45, 1'b1};
            checks++;
            if (obs1 !== exp1) begin
                errors++; $display("FAIL parity_even k=%0d got %b want %b", k, obs1, exp1);
            end
            checks++;
            if (obs2 !== exp2) begin
                errors++; $display("FAIL parity_odd k=%0d got %b want %b", k, obs2, exp2);
            end
        end
        @(posedge clk); #1 en[1] = 1'b0; en[2] = 1'b0;
        @(negedge clk); @(negedge clk);
        obs1 = {pin[1], done[1], busy[1]};
        obs2 = {pin[2], done[2], busy[2]};
        checks++;
        if ({obs1, obs2} !== 6'b100100) begin
            errors++; $display("FAIL parity_idle got %b want 100100", {obs1, obs2});
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] obs, exp;
        @(posedge clk); #1 data[3] = 8'hA3; en[3] = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            obs = {pin[3], done[3], busy[3]};
            exp = {(k <= 44) ? exp_line(8'hA3, 0, 1'b0, k) : 1'b1, k == 45, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL stop2_a3 k=%0d got %b want %b", k, obs, exp);
            end
        end
        // Data changes while waiting for release must not leak into anything.
        @(posedge clk); #1 en[3] = 1'b0; data[3] = 8'h0F;
        @(negedge clk);
        obs = {pin[3], done[3], busy[3]};
        checks++;
        if (obs !== 3'b101) begin
            errors++; $display("FAIL stop2_waitrel got %b want 101", obs);
        end
        @(negedge clk);
        obs = {pin[3], done[3], busy[3]};
        checks++;
        if (obs !== 3'b100) begin
            errors++; $display("FAIL stop2_gap got %b want 100", obs);
        end
        @(posedge clk); #1 en[3] = 1'b1;
        @(negedge clk);
        obs = {pin[3], done[3], busy[3]};
        checks++;
        if (obs !== 3'b100) begin
            errors++; $display("FAIL stop2_pre2 got %b want 100", obs);
        end
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            obs = {pin[3], done[3], busy[3]};
            exp = {(k <= 44) ? exp_line(8'h0F, 0, 1'b0, k) : 1'b1, k == 45, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL stop2_0f k=%0d got %b want %b", k, obs, exp);
            end
        end
        @(posedge clk); #1 en[3] = 1'b0;
        @(negedge clk); @(negedge clk);
        obs = {pin[3], done[3], busy[3]};
        checks++;
        if (obs !== 3'b100) begin
            errors++; $display("FAIL stop2_idle got %b want 100", obs);
        end
    endtask

    task automatic test_held_enable();
        logic [2:0] obs, exp;
        int ndone;
        ndone = 0;
        @(posedge clk); #1 data[0] = 8'h3C; en[0] = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 241; k++) begin
            @(negedge clk);
            if (done[0] === 1'b1) ndone++;
            obs = {pin[0], done[0], busy[0]};
            exp = {(k <= 40) ? exp_line(8'h3C, 0, 1'b0, k) : 1'b1, k == 41, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL held_frame k=%0d got %b want %b", k, obs, exp);
            end
        end
        checks++;
        if (ndone !== 1) begin
            errors++; $display("FAIL held_done_count got %0d want 1", ndone);
        end
        @(posedge clk); #1 en[0] = 1'b0;
        @(negedge clk); @(negedge clk);
        obs = {pin[0], done[0], busy[0]};
        checks++;
        if (obs !== 3'b100) begin
            errors++; $display("FAIL held_idle got %b want 100", obs);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] obs, exp;
        int ndone;
        ndone = 0;
        @(posedge clk); #1 data[0] = 8'hFF; en[0] = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            obs = {pin[0], done[0], busy[0]};
            exp = {exp_line(8'hFF, 0, 1'b0, k), 1'b0, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL rstmid_pre k=%0d got %b want %b", k, obs, exp);
            end
        end
        // Now inside data bit 3.
        #2 rst = 1'b1; data[0] = 8'h81;
        #1 obs = {pin[0], done[0], busy[0]};
        checks++;
        if (obs !== 3'b100) begin
            errors++; $display("FAIL rstmid_async got %b want 100", obs);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done[0] === 1'b1) ndone++;
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        obs = {pin[0], done[0], busy[0]};
        checks++;
        if (obs !== 3'b100) begin
            errors++; $display("FAIL rstmid_release got %b want 100", obs);
        end
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (done[0] === 1'b1) ndone++;
            obs = {pin[0], done[0], busy[0]};
            exp = {(k <= 40) ? exp_line(8'h81, 0, 1'b0, k) : 1'b1, k == 41, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL rstmid_81 k=%0d got %b want %b", k, obs, exp);
            end
        end
        checks++;
        if (ndone !== 1) begin
            errors++; $display("FAIL rstmid_done_count got %0d want 1", ndone);
        end
        @(posedge clk); #1 en[0] = 1'b0;
        @(negedge clk); @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            en[i]   = 1'b0;
            data[i] = 8'h00;
        end
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_held_enable();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
